if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline. Holds the program counter, drives the address of the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register together with PC+4. Supports hazard freeze (stall) and branch redirect with bubble insertion, and counts instructions delivered to decode.

## Interface

- `ADDR_W`, 32: PC / address width.
- `RESET_PC`, 0: PC value after reset; must be a multiple of 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `freeze` input 1: hazard stall from the hazard unit; holds the PC and the IF/ID register.
- `branch_taken` input 1: redirect request from EX.
- `branch_addr` input ADDR_W: redirect target.
- `inst_addr` output ADDR_W: address to instruction memory. Equals the PC register, combinational from state.
- `inst_in` input 32: instruction word returned combinationally for `inst_addr`.
- `pc_out` output ADDR_W: IF/ID register, PC+4 of the held instruction.
- `inst_out` output 32: IF/ID register, the held instruction.
- `valid_out` output 1: IF/ID register holds a real instruction. 0 means a bubble.
- `fetch_count` output 32: number of valid instructions loaded into IF/ID.

## Operation

- **State:** `pc`, `pc_out`, `inst_out`, `valid_out`, `fetch_count`.
- **`inst_addr`:** `inst_addr = pc` at all times. `next_seq = pc + 4`, computed modulo 2^ADDR_W (wraps silently).
- **Per-edge priority:** highest first.
  1. `rst_n == 0`:
     - `pc <= RESET_PC`
     - `pc_out <= 0`, `inst_out <= 0`, `valid_out <= 0`
     - `fetch_count <= 0`
  2. `branch_taken == 1`, regardless of `freeze`:
     - `pc <= {branch_addr[ADDR_W-1:2], 2'b00}`; the low two bits are forced to zero.
     - IF/ID loads a bubble: `inst_out <= 0`, `pc_out <= 0`, `valid_out <= 0`.
     - `fetch_count` holds.
  3. `freeze == 1`: `pc`, IF/ID and `fetch_count` all hold.
  4. Otherwise:
     - `pc <= next_seq`
     - `pc_out <= next_seq`, `inst_out <= inst_in`, `valid_out <= 1`
     - `fetch_count <= fetch_count + 1`, wrapping at 2^32.
- **Redirect cost:** a redirect always costs exactly one bubble cycle in IF/ID. The instruction at the target is fetched in the following cycle.
- **Alignment:** no alignment check on `pc`. `RESET_PC` alignment is the integrator's responsibility.
- **Unknown inputs:** X on `inst_in` during a freeze or branch cycle must not reach IF/ID.

## Timing

- **Reset:** `valid_out = 0`, `inst_out = 0`, `pc_out = 0`, `fetch_count = 0`, and `inst_addr = RESET_PC` in the first cycle after the reset edge.
- **Fetch latency:** if `inst_addr = A` in cycle n with no freeze or branch, then in cycle n+1 `inst_out = mem[A]`, `pc_out = A+4`, `valid_out = 1`.
- **Throughput:** one instruction per cycle when unstalled.
- **Freeze:** held for k cycles, the outputs stay frozen for exactly k cycles. Fetch resumes at the same `pc` with no instruction lost or duplicated.
- **Branch:** asserted in cycle n with target T. In cycle n+1, `inst_addr = T` and `valid_out = 0`. In cycle n+2, `inst_out = mem[T]` and `pc_out = T+4`.
- **Back-to-back branches:** every edge redirects; `valid_out` stays 0 throughout.
- **Reset during freeze or branch:** reset wins. Outputs take their reset values on that edge.

## Test plan

Bench memory model: `inst_in = {16'hA5A5, inst_addr[15:0]}`.

1. **Reset then free-run.**
   - Stimulus: `rst_n` low for 2 cycles, then high for 5 cycles.
   - Response: `inst_addr` runs 0, 4, 8, 12, 16.
   - Response: `inst_out` runs 0xA5A50000, 0xA5A50004, ..., lagging `inst_addr` by one cycle.
   - Response: `pc_out` = 4, 8, ...; `fetch_count` = 5 at the end.
2. **Freeze.**
   - Stimulus: at `pc = 8`, assert `freeze` for 3 cycles.
   - Response: `inst_addr` stays 8.
   - Response: `inst_out` stays 0xA5A50004 with `pc_out = 8`; `fetch_count` is unchanged.
   - Response: after release, next `inst_out` = 0xA5A50008.
3. **Branch redirect.**
   - Stimulus: at `pc = 12`, pulse `branch_taken` with `branch_addr = 0x40`.
   - Response: next cycle `inst_addr = 0x40`, `valid_out = 0`, `inst_out = 0`.
   - Response: the cycle after, `inst_out = 0xA5A50040` and `pc_out = 0x44`.
4. **Branch during freeze, misaligned target.**
   - Stimulus: `freeze = 1` and `branch_taken = 1` with `branch_addr = 0x23`.
   - Response: `inst_addr = 0x20` next cycle and a bubble is inserted.
5. **Back-to-back branches.**
   - Stimulus: branches to 0x100 and then 0x200 on consecutive cycles.
   - Response: `valid_out = 0` for 2 cycles; then `inst_out = 0xA5A50200`.
6. **Reset mid-operation and PC wrap.**
   - Stimulus: `rst_n` low while `freeze = 1` at `pc = 0x18`.
   - Response: `pc = RESET_PC` and all outputs return to reset values.
   - Stimulus: separately, branch to 0xFFFFFFFC and run 2 cycles.
   - Response: `inst_addr` wraps to 0, with `pc_out = 0` for the instruction fetched at 0xFFFFFFFC.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of a five-stage pipeline.
//
// Holds the program counter, drives the address of a combinational instruction
// memory and captures the returned word into the IF/ID pipeline register along
// with PC+4. A hazard freeze holds everything. A branch redirect reloads the PC
// and inserts one bubble. Every valid instruction delivered to decode is counted.
//
// Ports:
//   i_clk          clock; all state updates on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_freeze       hazard stall: hold PC, IF/ID and fetch count
//   i_branch_taken redirect request from EX (overrides freeze)
//   i_branch_addr  redirect target; low two bits are ignored
//   o_inst_addr    instruction memory address (equals the PC register)
//   i_inst_in      instruction word returned for o_inst_addr
//   o_pc_out       IF/ID: PC+4 of the held instruction
//   o_inst_out     IF/ID: held instruction
//   o_valid_out    IF/ID holds a real instruction (0 = bubble)
//   o_fetch_count  number of valid instructions loaded into IF/ID

module if_stage #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_freeze,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_addr,
  output logic [ADDR_W-1:0] o_inst_addr,
  input  logic [31:0]       i_inst_in,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic [31:0]       o_inst_out,
  output logic              o_valid_out,
  output logic [31:0]       o_fetch_count
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_inst_out;
  logic              r_valid_out;
  logic [31:0]       r_fetch_count;

  logic [ADDR_W-1:0] w_next_seq;
  logic [ADDR_W-1:0] w_branch_tgt;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_out_next;
  logic [31:0]       w_inst_out_next;
  logic              w_valid_out_next;
  logic [31:0]       w_fetch_count_next;

  // Sequential successor wraps silently at 2^ADDR_W.
  assign w_next_seq   = r_pc + ADDR_W'(4);
  assign w_branch_tgt = {i_branch_addr[ADDR_W-1:2], 2'b00};

  // Branch beats freeze. i_inst_in is only sampled on the plain fetch path, so
  // an unknown word during a freeze or redirect never reaches IF/ID.
  always_comb begin
    w_pc_next          = r_pc;
    w_pc_out_next      = r_pc_out;
    w_inst_out_next    = r_inst_out;
    w_valid_out_next   = r_valid_out;
    w_fetch_count_next = r_fetch_count;
    if (i_branch_taken) begin
      w_pc_next        = w_branch_tgt;
      w_pc_out_next    = '0;
      w_inst_out_next  = '0;
      w_valid_out_next = 1'b0;
    end else if (!i_freeze) begin
      w_pc_next          = w_next_seq;
      w_pc_out_next      = w_next_seq;
      w_inst_out_next    = i_inst_in;
      w_valid_out_next   = 1'b1;
      w_fetch_count_next = r_fetch_count + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_pc_out      <= '0;
      r_inst_out    <= '0;
      r_valid_out   <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_pc_out      <= w_pc_out_next;
      r_inst_out    <= w_inst_out_next;
      r_valid_out   <= w_valid_out_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  assign o_inst_addr   = r_pc;
  assign o_pc_out      = r_pc_out;
  assign o_inst_out    = r_inst_out;
  assign o_valid_out   = r_valid_out;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. Memory model: inst = {16'hA5A5, addr[15:0]}.
// Inputs change and outputs are sampled on the falling edge.

module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic [31:0] fetch_count;
  logic        xmode;

  int checks;
  int failures;

  if_stage #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_freeze      (freeze),
    .i_branch_taken(branch_taken),
    .i_branch_addr (branch_addr),
    .o_inst_addr   (inst_addr),
    .i_inst_in     (inst_in),
    .o_pc_out      (pc_out),
    .o_inst_out    (inst_out),
    .o_valid_out   (valid_out),
    .o_fetch_count (fetch_count)
  );

  // Memory model; xmode feeds garbage to show it never reaches IF/ID.
  assign inst_in = xmode ? 32'hDEAD_BEEF : {16'hA5A5, inst_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; xmode = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_out !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 ||
        fetch_count !== 32'h0 || inst_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset: got valid=%0b inst=%h pc_out=%h cnt=%0d addr=%h, want 0/0/0/0/0",
               valid_out, inst_out, pc_out, fetch_count, inst_addr);
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (inst_out !== 32'hA5A5_0000 + 32'(4 * i) || pc_out !== 32'(4 * (i + 1)) ||
          inst_addr !== 32'(4 * (i + 1)) || valid_out !== 1'b1) begin
        failures++;
        $display("FAIL free_run[%0d]: got inst=%h pc_out=%h addr=%h valid=%0b, want %h/%h/%h/1",
                 i, inst_out, pc_out, inst_addr, valid_out, 32'hA5A5_0000 + 32'(4 * i),
                 32'(4 * (i + 1)), 32'(4 * (i + 1)));
      end
    end
    checks++;
    if (fetch_count !== 32'd5) begin
      failures++;
      $display("FAIL free_run_count: got %0d want 5", fetch_count);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    step(); step();  // pc = 8, IF/ID holds instruction from 4
    freeze = 1'b1;
    xmode  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_addr !== 32'h8 || inst_out !== 32'hA5A5_0004 || pc_out !== 32'h8 ||
          fetch_count !== 32'd2 || valid_out !== 1'b1) begin
        failures++;
        $display("FAIL freeze[%0d]: got addr=%h inst=%h pc_out=%h cnt=%0d valid=%0b, want 8/a5a50004/8/2/1",
                 i, inst_addr, inst_out, pc_out, fetch_count, valid_out);
      end
    end
    freeze = 1'b0;
    xmode  = 1'b0;
    step();
    checks++;
    if (inst_out !== 32'hA5A5_0008 || pc_out !== 32'hC || inst_addr !== 32'hC ||
        fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL freeze_release: got inst=%h pc_out=%h addr=%h cnt=%0d, want a5a50008/c/c/3",
               inst_out, pc_out, inst_addr, fetch_count);
    end
  endtask

  task automatic test_branch();
    // pc = 12 here
    branch_taken = 1'b1; branch_addr = 32'h40; xmode = 1'b1;
    step();
    branch_taken = 1'b0; xmode = 1'b0;
    checks++;
    if (inst_addr !== 32'h40 || valid_out !== 1'b0 || inst_out !== 32'h0 ||
        pc_out !== 32'h0 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL branch_bubble: got addr=%h valid=%0b inst=%h pc_out=%h cnt=%0d, want 40/0/0/0/3",
               inst_addr, valid_out, inst_out, pc_out, fetch_count);
    end
    step();
    checks++;
    if (inst_out !== 32'hA5A5_0040 || pc_out !== 32'h44 || valid_out !== 1'b1 ||
        fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL branch_target: got inst=%h pc_out=%h valid=%0b cnt=%0d, want a5a50040/44/1/4",
               inst_out, pc_out, valid_out, fetch_count);
    end
  endtask

  task automatic test_branch_freeze();
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h23; xmode = 1'b1;
    step();
    freeze = 1'b0; branch_taken = 1'b0; xmode = 1'b0;
    checks++;
    if (inst_addr !== 32'h20 || valid_out !== 1'b0 || inst_out !== 32'h0 ||
        fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL branch_freeze: got addr=%h valid=%0b inst=%h cnt=%0d, want 20/0/0/4",
               inst_addr, valid_out, inst_out, fetch_count);
    end
    step();
    checks++;
    if (inst_out !== 32'hA5A5_0020 || pc_out !== 32'h24 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL branch_freeze_target: got inst=%h pc_out=%h valid=%0b, want a5a50020/24/1",
               inst_out, pc_out, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    checks++;
    if (valid_out !== 1'b0 || inst_addr !== 32'h100) begin
      failures++;
      $display("FAIL b2b_first: got valid=%0b addr=%h, want 0/100", valid_out, inst_addr);
    end
    branch_addr = 32'h200;
    step();
    branch_taken = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || inst_addr !== 32'h200 || inst_out !== 32'h0) begin
      failures++;
      $display("FAIL b2b_second: got valid=%0b addr=%h inst=%h, want 0/200/0",
               valid_out, inst_addr, inst_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b1 || inst_out !== 32'hA5A5_0200 || pc_out !== 32'h204 ||
        fetch_count !== 32'd6) begin
      failures++;
      $display("FAIL b2b_target: got valid=%0b inst=%h pc_out=%h cnt=%0d, want 1/a5a50200/204/6",
               valid_out, inst_out, pc_out, fetch_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) step();  // pc = 0x18
    freeze = 1'b1; rst_n = 1'b0;
    step();
    checks++;
    if (inst_addr !== 32'h0 || valid_out !== 1'b0 || inst_out !== 32'h0 ||
        pc_out !== 32'h0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_freeze: got addr=%h valid=%0b inst=%h pc_out=%h cnt=%0d, want all 0",
               inst_addr, valid_out, inst_out, pc_out, fetch_count);
    end
    // Reset also beats a branch on the same edge.
    freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80;
    step();
    branch_taken = 1'b0; rst_n = 1'b1;
    checks++;
    if (inst_addr !== 32'h0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_branch: got addr=%h cnt=%0d, want 0/0", inst_addr, fetch_count);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    checks++;
    if (inst_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_target: got addr=%h want fffffffc", inst_addr);
    end
    step();
    checks++;
    if (inst_addr !== 32'h0 || pc_out !== 32'h0 || inst_out !== 32'hA5A5_FFFC ||
        valid_out !== 1'b1 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL wrap: got addr=%h pc_out=%h inst=%h valid=%0b cnt=%0d, want 0/0/a5a5fffc/1/1",
               inst_addr, pc_out, inst_out, valid_out, fetch_count);
    end
    step();
    checks++;
    if (inst_out !== 32'hA5A5_0000 || pc_out !== 32'h4 || inst_addr !== 32'h4) begin
      failures++;
      $display("FAIL wrap_next: got inst=%h pc_out=%h addr=%h, want a5a50000/4/4",
               inst_out, pc_out, inst_addr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; xmode = 1'b0;
    test_reset();
    test_free_run();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
